sysarray_operand_feeder: RTL and testbench
==========================================

// Module: sysarray_operand_feeder
// PURPOSE
//  Upstream stage of the 4x4 SystolicArray_ADD. Buffers one 4x4 A matrix and one 4x4 B matrix.
//  Operands arrive one element pair per beat. The block then clears the array accumulators and
//  emits A rows and B columns as diagonally skewed streams. After the array pipeline drains, it
//  pulses done, which arrayMean and the result capture logic consume.
// PARAMETERS
//  WIDTH         8   signed operand width; matches the array's `width
//  DRAIN_CYCLES  5   idle cycles after the last skewed beat, before done
// PORTS
//  clk         in   1        rising-edge clock
//  _reset      in   1        asynchronous, active-low reset
//  in_valid    in   1        a_in/b_in hold a valid element pair
//  in_ready    out  1        feeder accepts a pair this cycle
//  a_in        in   WIDTH    A element, row-major order
//  b_in        in   WIDTH    B element, row-major order
//  _flush_acc  out  1        active-low accumulator clear to the array
//  a_row       out  4*WIDTH  skewed A row streams; [WIDTH*i +: WIDTH] = row i
//  b_col       out  4*WIDTH  skewed B column streams; [WIDTH*j +: WIDTH] = column j
//  busy        out  1        high from the first accepted beat until done is asserted
//  done        out  1        one-cycle pulse; array results are final
// BEHAVIOUR
//  Reset (async, _reset=0): state LOAD, beat count 0, in_ready=1, _flush_acc=1, a_row=0,
//   b_col=0, busy=0, done=0. Buffer contents are don't-care. Reset mid-operation aborts the
//   frame immediately; all partial data is discarded.
//  All outputs are registered. A beat is accepted when in_valid & in_ready.
//  LOAD: in_ready=1. Accepted beat k (0..15) writes A[k/4][k%4]=a_in and B[k/4][k%4]=b_in.
//   busy goes to 1 the cycle after beat 0. in_valid gaps are allowed; the count holds.
//   The cycle after beat 15 is accepted, the state becomes FLUSH.
//  FLUSH: 1 cycle. _flush_acc=0, in_ready=0, a_row=b_col=0. Next state is STREAM with t=0.
//  STREAM: t = 0..6, 7 cycles, in_ready=0.
//   a_row[i] = A[i][t-i] when 0<=t-i<=3, else 0.
//   b_col[j] = B[t-j][j] when 0<=t-j<=3, else 0.
//   After t=6 the next state is DRAIN.
//  DRAIN: DRAIN_CYCLES cycles. a_row=b_col=0, in_ready=0.
//  DONE: 1 cycle. done=1, busy=0 in the same cycle. in_ready returns to 1 in the following
//   cycle, when the state is back to LOAD with count 0.
//  in_valid while in_ready=0 is ignored; the data is not stored and not counted.
//  Values pass through unmodified (signed WIDTH bits). No arithmetic or saturation.
//  Frame length with no input gaps: 16 load beats + 1 + 7 + DRAIN_CYCLES + 1.
//   With the default DRAIN_CYCLES this is 30 cycles from the first beat to the done pulse.
// TESTING
//  1. A=0..15 and B=16..31, row-major, no gaps.
//     -> FLUSH low for exactly 1 cycle.
//     -> Cycle t=0: a_row={0,0,0,0}, b_col={0,0,0,16}.
//     -> Cycle t=3: a_row[3]=12, a_row[0]=3, b_col[3]=19.
//     -> done pulses 30 cycles after the first beat.
//  2. A=identity, B=all 0x7F, fed to SystolicArray_ADD.
//     -> After done, every product output is 0x007F.
//     -> busy falls in the done cycle.
//  3. Random in_valid gaps (~50% duty).
//     -> Skewed output matches test 1 exactly.
//     -> Exactly 16 beats accepted.
//     -> in_valid held high during STREAM accepts nothing.
//  4. Signed extremes: A=0x80 and B=0x7F in all entries.
//     -> Streams carry 0x80 and 0x7F unaltered.
//     -> Zero fill is 0x00 outside the skew window.
//  5. _reset pulled low at STREAM t=2.
//     -> All outputs return to reset values asynchronously.
//     -> A new frame reloads cleanly; no stale data appears on the streams.
//  6. Two frames back-to-back.
//     -> Second beat 0 is accepted in the cycle after done.
//     -> The second frame's streams are independent of the first.

Source files
------------

// File: rtl/sysarray_operand_feeder.sv
// Operand feeder for the 4x4 systolic array.
// Loads one 4x4 A matrix and one 4x4 B matrix, one element pair per beat.
// Then clears the array accumulators and emits diagonally skewed A-row and
// B-column streams. After the pipeline drains it pulses done.
module sysarray_operand_feeder #(
    parameter int WIDTH        = 8,
    parameter int DRAIN_CYCLES = 5
) (
    input  logic               clk,
    input  logic               _reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a_in,
    input  logic [WIDTH-1:0]   b_in,
    output logic               _flush_acc,
    output logic [4*WIDTH-1:0] a_row,
    output logic [4*WIDTH-1:0] b_col,
    output logic               busy,
    output logic               done
);

    localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_LOAD,
        S_FLUSH,
        S_STREAM,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t             state;
    logic [3:0]         beat_cnt;
    logic [2:0]         t_cnt;
    logic [DW-1:0]      drain_cnt;
    logic [WIDTH-1:0]   a_buf [16];
    logic [WIDTH-1:0]   b_buf [16];
    logic               accept;
    logic [2:0]         t_next;
    logic [4*WIDTH-1:0] a_skew;
    logic [4*WIDTH-1:0] b_skew;

    // in_ready is high only in LOAD, so accepted beats can only land there
    assign accept = in_valid & in_ready;

    // Operand buffer; contents are don't-care out of reset, so no reset here
    always_ff @(posedge clk) begin
        if (accept) begin
            a_buf[beat_cnt] <= a_in;
            b_buf[beat_cnt] <= b_in;
        end
    end

    // Skewed beat for the next stream step: lane i carries A[i][t-i], lane j carries B[t-j][j]
    always_comb begin
        t_next = (state == S_FLUSH) ? 3'd0 : t_cnt + 3'd1;
        a_skew = '0;
        b_skew = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            for (int unsigned d = 0; d < 4; d++) begin
                if (3'(i + d) == t_next) begin
                    a_skew[WIDTH*i +: WIDTH] = a_buf[4'(4*i + d)];
                    b_skew[WIDTH*i +: WIDTH] = b_buf[4'(4*d + i)];
                end
            end
        end
    end

    // Frame sequencer with registered outputs
    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            state      <= S_LOAD;
            beat_cnt   <= '0;
            t_cnt      <= '0;
            drain_cnt  <= '0;
            in_ready   <= 1'b1;
            _flush_acc <= 1'b1;
            a_row      <= '0;
            b_col      <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            case (state)
                S_LOAD: begin
                    if (accept) begin
                        busy     <= 1'b1;
                        beat_cnt <= beat_cnt + 4'd1;
                        if (beat_cnt == 4'd15) begin
                            state      <= S_FLUSH;
                            in_ready   <= 1'b0;
                            _flush_acc <= 1'b0;
                        end
                    end
                end
                S_FLUSH: begin
                    _flush_acc <= 1'b1;
                    t_cnt      <= '0;
                    a_row      <= a_skew;
                    b_col      <= b_skew;
                    state      <= S_STREAM;
                end
                S_STREAM: begin
                    if (t_cnt == 3'd6) begin
                        state     <= S_DRAIN;
                        drain_cnt <= '0;
                        a_row     <= '0;
                        b_col     <= '0;
                    end else begin
                        t_cnt <= t_cnt + 3'd1;
                        a_row <= a_skew;
                        b_col <= b_skew;
                    end
                end
                S_DRAIN: begin
                    if (drain_cnt == DW'(DRAIN_CYCLES - 1)) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end else begin
                        drain_cnt <= drain_cnt + DW'(1);
                    end
                end
                S_DONE: begin
                    state    <= S_LOAD;
                    done     <= 1'b0;
                    in_ready <= 1'b1;
                    beat_cnt <= '0;
                end
                default: state <= S_LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_sysarray_operand_feeder.sv
// Scoreboard bench for sysarray_operand_feeder: stimulus pushes expected
// skewed beats, a negedge monitor tracks the frame and compares.
module tb_sysarray_operand_feeder;

    localparam int WIDTH = 8;
    localparam int DRAIN = 5;

    logic        clk = 1'b0;
    logic        _reset;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  a_in;
    logic [7:0]  b_in;
    logic        _flush_acc;
    logic [31:0] a_row;
    logic [31:0] b_col;
    logic        busy;
    logic        done;

    always #5 clk = ~clk;

    sysarray_operand_feeder #(
        .WIDTH(WIDTH),
        .DRAIN_CYCLES(DRAIN)
    ) dut (
        .clk(clk),
        ._reset(_reset),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .a_in(a_in),
        .b_in(b_in),
        ._flush_acc(_flush_acc),
        .a_row(a_row),
        .b_col(b_col),
        .busy(busy),
        .done(done)
    );

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
    } beat_t;

    int    n_tests = 0;
    int    n_fail  = 0;
    beat_t exp_q[$];
    int    cyc = 0;

    logic [7:0] ma [16];
    logic [7:0] mb [16];

    // Hand-computed skew for A=0..15, B=16..31 (t = 0..6), {a_row, b_col}
    logic [63:0] t1_tab [7] = '{
        {32'h00000000, 32'h00000010},
        {32'h00000401, 32'h00001114},
        {32'h00080502, 32'h00121518},
        {32'h0C090603, 32'h1316191C},
        {32'h0D0A0700, 32'h171A1D00},
        {32'h0E0B0000, 32'h1B1E0000},
        {32'h0F000000, 32'h1F000000}
    };

    // monitor state
    int    phase = 0;
    int    sidx = 0;
    int    didx = 0;
    int    acc_cnt = 0;
    int    first_cyc = 0;
    int    done_cyc = 0;
    int    frames_done = 0;
    bit    expect_ready = 0;
    bit    chk_b2b = 0;
    bit    gapless = 1;
    beat_t e;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_hand_t1();
        for (int t = 0; t < 7; t++) exp_q.push_back(beat_t'(t1_tab[t]));
    endtask

    task automatic push_model();
        beat_t m;
        for (int t = 0; t < 7; t++) begin
            m = '0;
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++) begin
                    if (r + c == t) m.a[8*r +: 8] = ma[4*r + c];
                    if (r + c == t) m.b[8*c +: 8] = mb[4*r + c];
                end
            exp_q.push_back(m);
        end
    endtask

    // Feed 16 beats; with gaps, in_valid is randomly dropped about half the time
    task automatic send_frame(input bit gaps);
        int  k;
        int  guard;
        bit  v;
        bit  acc;
        k = 0;
        guard = 0;
        gapless = !gaps;
        while (k < 16 && guard < 300) begin
            v = !gaps || ($urandom_range(0, 1) == 1);
            in_valid = v;
            a_in = ma[k];
            b_in = mb[k];
            @(negedge clk);
            acc = v && in_ready;
            @(posedge clk);
            #1;
            if (acc) k++;
            guard++;
        end
        in_valid = 1'b0;
        if (k < 16) begin
            n_tests++;
            n_fail++;
            $display("FAIL send_timeout: got %0d beats expected 16", k);
        end
    endtask

    task automatic wait_frames(input int n);
        int guard;
        guard = 0;
        while (frames_done < n && guard < 300) begin
            @(posedge clk);
            guard++;
        end
        #1;
        if (frames_done < n) begin
            n_tests++;
            n_fail++;
            $display("FAIL done_timeout: got %0d frames expected %0d", frames_done, n);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, in_ready, 1);
        check({tag, "_flush_acc"}, _flush_acc, 1);
        check({tag, "_a_row"}, a_row, 0);
        check({tag, "_b_col"}, b_col, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
    endtask

    // Monitor: follows LOAD -> FLUSH -> STREAM -> DRAIN -> DONE and scores outputs
    always @(negedge clk) begin
        if (!_reset) begin
            phase = 0;
            acc_cnt = 0;
            expect_ready = 0;
        end else begin
            case (phase)
                0: begin
                    if (expect_ready) begin
                        check("ready_after_done", in_ready, 1);
                        check("done_one_cycle", done, 0);
                        expect_ready = 0;
                    end
                    check("load_busy", busy, (acc_cnt > 0) ? 1 : 0);
                    if (_flush_acc == 1'b0) begin
                        check("beats_accepted", acc_cnt, 16);
                        check("flush_a_row", a_row, 0);
                        check("flush_b_col", b_col, 0);
                        check("flush_in_ready", in_ready, 0);
                        phase = 1;
                        sidx = 0;
                    end else if (in_valid && in_ready) begin
                        if (acc_cnt == 0) begin
                            first_cyc = cyc;
                            if (chk_b2b) begin
                                check("b2b_first_beat", cyc, done_cyc + 1);
                                chk_b2b = 0;
                            end
                        end
                        acc_cnt++;
                    end
                end
                1: begin
                    if (exp_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL stream_unexpected: got a=%h b=%h expected no beat", a_row, b_col);
                    end else begin
                        e = exp_q.pop_front();
                        check("stream_a_row", a_row, e.a);
                        check("stream_b_col", b_col, e.b);
                    end
                    check("stream_flush_hi", _flush_acc, 1);
                    check("stream_in_ready", in_ready, 0);
                    check("stream_busy", busy, 1);
                    sidx++;
                    if (sidx == 7) begin
                        phase = 2;
                        didx = 0;
                    end
                end
                2: begin
                    check("drain_a_row", a_row, 0);
                    check("drain_b_col", b_col, 0);
                    check("drain_done", done, 0);
                    check("drain_in_ready", in_ready, 0);
                    didx++;
                    if (didx == DRAIN) phase = 3;
                end
                default: begin
                    check("done_pulse", done, 1);
                    check("done_busy_low", busy, 0);
                    check("done_in_ready", in_ready, 0);
                    // 30-cycle frame counted inclusively from beat 0 to the done cycle
                    if (gapless) check("frame_latency", cyc - first_cyc, 29);
                    done_cyc = cyc;
                    frames_done++;
                    acc_cnt = 0;
                    expect_ready = 1;
                    phase = 0;
                end
            endcase
        end
    end

    initial begin
        int gw;
        _reset = 1'b0;
        in_valid = 1'b0;
        a_in = '0;
        b_in = '0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        _reset = 1'b1;
        @(posedge clk);
        #1;

        // 1: sequential data, no gaps, hand-computed streams
        for (int k = 0; k < 16; k++) begin ma[k] = 8'(k); mb[k] = 8'(16 + k); end
        push_hand_t1();
        send_frame(0);
        wait_frames(1);

        // 2: identity A, all-0x7F B
        for (int k = 0; k < 16; k++) begin
            ma[k] = (k / 4 == k % 4) ? 8'h01 : 8'h00;
            mb[k] = 8'h7F;
        end
        push_model();
        send_frame(0);
        wait_frames(2);

        // 3: random in_valid gaps, then in_valid held high through STREAM
        for (int k = 0; k < 16; k++) begin ma[k] = 8'(k); mb[k] = 8'(16 + k); end
        push_hand_t1();
        send_frame(1);
        in_valid = 1'b1;
        a_in = 8'hEE;
        b_in = 8'hDD;
        wait_frames(3);
        in_valid = 1'b0;

        // 4: signed extremes
        for (int k = 0; k < 16; k++) begin ma[k] = 8'h80; mb[k] = 8'h7F; end
        push_model();
        send_frame(0);
        wait_frames(4);

        // 5: reset at STREAM t=2, then a clean reload
        for (int k = 0; k < 16; k++) begin ma[k] = 8'(8'hA0 + k); mb[k] = 8'(8'hC0 + k); end
        push_model();
        send_frame(0);
        gw = 0;
        while (_flush_acc !== 1'b0 && gw < 20) begin @(negedge clk); gw++; end
        check("abort_saw_flush", _flush_acc, 0);
        @(negedge clk);
        @(negedge clk);
        @(posedge clk);
        #2;
        _reset = 1'b0;
        exp_q.delete();
        #1;
        check_reset_outputs("async_reset");
        @(posedge clk);
        #1;
        check_reset_outputs("held_reset");
        _reset = 1'b1;
        @(posedge clk);
        #1;
        for (int k = 0; k < 16; k++) begin ma[k] = 8'(8'h40 + k); mb[k] = 8'(8'h60 + k); end
        push_model();
        send_frame(0);
        wait_frames(5);

        // 6: two frames back-to-back
        for (int k = 0; k < 16; k++) begin ma[k] = 8'(3 * k); mb[k] = 8'(255 - k); end
        push_model();
        send_frame(0);
        chk_b2b = 1;
        for (int k = 0; k < 16; k++) begin ma[k] = 8'(8'h55 ^ k); mb[k] = 8'(7 * k); end
        push_model();
        send_frame(0);
        wait_frames(7);

        check("scoreboard_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

endmodule
